// File: rtl/sif_pkg.sv
// Shared definitions for the SIF slave: default widths, op encoding and the
// read-data address scramble.
package sif_pkg;

  localparam int unsigned SIF_ADDR_W = 16;
  localparam int unsigned SIF_DATA_W = 16;

  // Op code is {rst_n, wr_s, rd_s}; any code with rst_n low is a reset.
  typedef enum logic [2:0] {
    OpReset = 3'b000,
    OpIdle  = 3'b100,
    OpRead  = 3'b101,
    OpWrite = 3'b110,
    OpWrRd  = 3'b111
  } op_e;

  function automatic logic [SIF_ADDR_W-1:0] scramble_addr(input logic [SIF_ADDR_W-1:0] a);
    logic [SIF_ADDR_W-1:0] r;
    r    = a;
    r[8] = a[8] ^ a[4];
    r[7] = a[7] ^ a[5];
    return r;
  endfunction

endpackage

// File: rtl/sif_if.sv
// SIF bus bundle: host-side xa port plus forwarded wa write port.
interface sif_if
  import sif_pkg::*;
#(
  parameter int unsigned ADDR_W = SIF_ADDR_W,
  parameter int unsigned DATA_W = SIF_DATA_W
);

  logic [ADDR_W-1:0] xa_addr;
  logic [DATA_W-1:0] xa_data_wr;
  logic              xa_wr_s;
  logic              xa_rd_s;
  logic [DATA_W-1:0] xa_data_rd;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data_wr;
  logic              wa_wr_s;

  modport master (
    output xa_addr, xa_data_wr, xa_wr_s, xa_rd_s,
    input  xa_data_rd, wa_addr, wa_data_wr, wa_wr_s
  );

  modport slave (
    input  xa_addr, xa_data_wr, xa_wr_s, xa_rd_s,
    output xa_data_rd, wa_addr, wa_data_wr, wa_wr_s
  );

endinterface

// File: rtl/sif_addr_scramble.sv
// Combinational read-data scramble: bits 8 and 7 pick up bits 4 and 5.
module sif_addr_scramble #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [ADDR_W-1:0] o_addr
);

  always_comb begin
    o_addr    = i_addr;
    o_addr[8] = i_addr[8] ^ i_addr[4];
    o_addr[7] = i_addr[7] ^ i_addr[5];
  end

endmodule

// File: rtl/sif_modport.sv
// SIF slave: registers xa writes onto the wa port and answers xa reads with
// the scrambled read address, both with one cycle of latency.
module sif_modport
  import sif_pkg::*;
#(
  parameter int unsigned ADDR_W = SIF_ADDR_W,
  parameter int unsigned DATA_W = SIF_DATA_W
) (
  input logic  clk,
  input logic  rst_n,
  sif_if.slave bus
);

  logic [2:0]        w_op;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_scr;

  logic              r_wa_wr_s;
  logic [ADDR_W-1:0] r_wa_addr;
  logic [DATA_W-1:0] r_wa_data;
  logic [DATA_W-1:0] r_rd_data;

  sif_addr_scramble #(
    .ADDR_W (ADDR_W)
  ) u_scramble (
    .i_addr (bus.xa_addr),
    .o_addr (w_scr)
  );

  assign w_op = {rst_n, bus.xa_wr_s, bus.xa_rd_s};

  // Read and write paths are independent, so OpWrRd enables both.
  always_comb begin
    w_wr_en = 1'b0;
    w_rd_en = 1'b0;
    case (w_op)
      OpWrite: w_wr_en = 1'b1;
      OpRead:  w_rd_en = 1'b1;
      OpWrRd: begin
        w_wr_en = 1'b1;
        w_rd_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wa_wr_s <= 1'b0;
      r_wa_addr <= '0;
      r_wa_data <= '0;
      r_rd_data <= '0;
    end else begin
      r_wa_wr_s <= w_wr_en;
      if (w_wr_en) begin
        r_wa_addr <= bus.xa_addr;
        r_wa_data <= bus.xa_data_wr;
      end
      if (w_rd_en) begin
        r_rd_data <= w_scr;
      end
    end
  end

  assign bus.wa_wr_s    = r_wa_wr_s;
  assign bus.wa_addr    = r_wa_addr;
  assign bus.wa_data_wr = r_wa_data;
  assign bus.xa_data_rd = r_rd_data;

endmodule

// File: tb/tb_sif_modport.sv
// Bench for sif_modport: directed checks with literal expectations plus random
// traffic compared every cycle against a queue-based reference model.
module tb_sif_modport;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  bit   started;

  sif_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  sif_modport u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] scr(input logic [15:0] a);
    return a ^ {7'b0, a[4], a[5], 7'b0};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: writes queue up and emerge one per cycle; reads hold the
  // latest scrambled address.
  logic [15:0] wq_addr[$];
  logic [15:0] wq_data[$];
  logic [15:0] m_wa_addr = '0;
  logic [15:0] m_wa_data = '0;
  logic [15:0] m_rd      = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wq_addr.delete();
      wq_data.delete();
      m_wa_addr = '0;
      m_wa_data = '0;
      m_rd      = '0;
    end else begin
      if (bus.xa_wr_s) begin
        wq_addr.push_back(bus.xa_addr);
        wq_data.push_back(bus.xa_data_wr);
      end
      if (bus.xa_rd_s) m_rd = scr(bus.xa_addr);
    end
  end

  always @(posedge clk) begin
    logic exp_wr;
    #1;
    if (started) begin
      exp_wr = (wq_addr.size() != 0);
      chk("wa_wr_s", {15'b0, bus.wa_wr_s}, {15'b0, exp_wr});
      if (exp_wr) begin
        m_wa_addr = wq_addr.pop_front();
        m_wa_data = wq_data.pop_front();
      end
      chk("wa_addr", bus.wa_addr, m_wa_addr);
      chk("wa_data_wr", bus.wa_data_wr, m_wa_data);
      chk("xa_data_rd", bus.xa_data_rd, m_rd);
    end
  end

  task automatic step(input logic wr, input logic rd, input logic [15:0] addr,
                      input logic [15:0] data);
    @(negedge clk);
    bus.xa_wr_s    = wr;
    bus.xa_rd_s    = rd;
    bus.xa_addr    = addr;
    bus.xa_data_wr = data;
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    started        = 1'b0;
    rst_n          = 1'b1;
    bus.xa_addr    = 16'h1234;
    bus.xa_data_wr = 16'h5678;
    bus.xa_wr_s    = 1'b1;
    bus.xa_rd_s    = 1'b1;
    #1;
    rst_n   = 1'b0;
    started = 1'b1;
    #1;
    chk("rst_wa_wr_s", {15'b0, bus.wa_wr_s}, 16'h0);
    chk("rst_xa_data_rd", bus.xa_data_rd, 16'h0);
    repeat (5) @(posedge clk);
    #2;
    chk("rst_hold_wa_addr", bus.wa_addr, 16'h0);
    chk("rst_hold_xa_data_rd", bus.xa_data_rd, 16'h0);

    @(negedge clk);
    rst_n       = 1'b1;
    bus.xa_wr_s = 1'b0;
    bus.xa_rd_s = 1'b0;
    @(posedge clk);
    #2;
    chk("post_rst_wa_wr_s", {15'b0, bus.wa_wr_s}, 16'h0);
    chk("post_rst_wa_data_wr", bus.wa_data_wr, 16'h0);

    step(1'b1, 1'b0, 16'h0040, 16'hBEEF);
    chk("wr_wa_wr_s", {15'b0, bus.wa_wr_s}, 16'h1);
    chk("wr_wa_addr", bus.wa_addr, 16'h0040);
    chk("wr_wa_data_wr", bus.wa_data_wr, 16'hBEEF);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("wr_end_wa_wr_s", {15'b0, bus.wa_wr_s}, 16'h0);
    chk("wr_hold_wa_addr", bus.wa_addr, 16'h0040);

    step(1'b0, 1'b1, 16'h0110, 16'h0);
    chk("rd_0110", bus.xa_data_rd, 16'h0010);
    step(1'b0, 1'b1, 16'h0020, 16'h0);
    chk("rd_0020", bus.xa_data_rd, 16'h00A0);
    step(1'b0, 1'b1, 16'h0180, 16'h0);
    chk("rd_0180", bus.xa_data_rd, 16'h0180);
    step(1'b0, 1'b1, 16'hFFFF, 16'h0);
    chk("rd_FFFF", bus.xa_data_rd, 16'hFE7F);
    step(1'b0, 1'b0, 16'h0000, 16'h0);
    chk("rd_hold", bus.xa_data_rd, 16'hFE7F);

    step(1'b1, 1'b0, 16'h0005, 16'h1111);
    chk("mix_wa_wr_s", {15'b0, bus.wa_wr_s}, 16'h1);
    chk("mix_wa_addr", bus.wa_addr, 16'h0005);
    chk("mix_wa_data_wr", bus.wa_data_wr, 16'h1111);
    step(1'b0, 1'b1, 16'h0020, 16'h0);
    chk("mix_rd", bus.xa_data_rd, 16'h00A0);
    chk("mix_no_pulse", {15'b0, bus.wa_wr_s}, 16'h0);
    step(1'b0, 1'b0, 16'h0000, 16'h0);
    chk("mix_idle_wa_wr_s", {15'b0, bus.wa_wr_s}, 16'h0);

    step(1'b1, 1'b1, 16'h0110, 16'hAAAA);
    chk("both_wa_wr_s", {15'b0, bus.wa_wr_s}, 16'h1);
    chk("both_wa_addr", bus.wa_addr, 16'h0110);
    chk("both_wa_data_wr", bus.wa_data_wr, 16'hAAAA);
    chk("both_rd", bus.xa_data_rd, 16'h0010);

    // Read launched, then reset pulled before the sampling edge.
    @(negedge clk);
    bus.xa_wr_s = 1'b0;
    bus.xa_rd_s = 1'b1;
    bus.xa_addr = 16'h0020;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_async_rd", bus.xa_data_rd, 16'h0);
    @(posedge clk);
    #2;
    chk("midrst_rd", bus.xa_data_rd, 16'h0);
    chk("midrst_wa_wr_s", {15'b0, bus.wa_wr_s}, 16'h0);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.xa_rd_s = 1'b0;
    step(1'b0, 1'b1, 16'h0180, 16'h0);
    chk("resume_rd", bus.xa_data_rd, 16'h0180);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 39) == 0) rst_n = 1'b0;
      bus.xa_wr_s    = 1'($urandom_range(0, 1));
      bus.xa_rd_s    = 1'($urandom_range(0, 1));
      bus.xa_addr    = 16'($urandom);
      bus.xa_data_wr = 16'($urandom);
    end
    @(negedge clk);
    rst_n       = 1'b1;
    bus.xa_wr_s = 1'b0;
    bus.xa_rd_s = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sif_modport.md
Name: sif_modport

Overview:
- Simple-interface (SIF) slave block between a host-side "xa" port and a write-out "wa" port.
- xa writes are forwarded, registered, to the wa port.
- xa reads return a fixed address-scrambling function of the read address, one cycle later.
- Sits behind the sif interface DUT modport; the bench drives xa and monitors both xa and wa.

Parameters:
- ADDR_W, 16, address width; the scramble bit positions require at least 9.
- DATA_W, 16, data width; must equal ADDR_W because read data is derived from the address.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- xa_addr  in  ADDR_W  host address for the current read or write.
- xa_data_wr  in  DATA_W  host write data.
- xa_wr_s  in  1  host write strobe; one write per cycle while high.
- xa_rd_s  in  1  host read strobe; one read per cycle while high.
- xa_data_rd  out  DATA_W  read data, valid the cycle after the read strobe is sampled.
- wa_addr  out  ADDR_W  forwarded write address.
- wa_data_wr  out  DATA_W  forwarded write data.
- wa_wr_s  out  1  forwarded write strobe.

Behaviour:
- Reset
  - rst_n low clears all outputs to 0 immediately, without waiting for a clock edge.
  - Outputs stay at 0 while rst_n is low; strobes are ignored.
- Write path
  - When xa_wr_s is sampled high at edge N, at edge N+1 the block registers: wa_wr_s=1, wa_addr=xa_addr, wa_data_wr=xa_data_wr.
  - This gives exactly one cycle of latency.
  - When xa_wr_s is sampled low, wa_wr_s=0 at the next edge; wa_addr and wa_data_wr hold their last values.
  - Back-to-back writes produce back-to-back wa_wr_s pulses with no gaps, in the same order.
- Read path
  - When xa_rd_s is sampled high at edge N, at edge N+1 the block registers xa_data_rd = scramble(xa_addr).
  - scramble(a) = {a[15:9], a[8]^a[4], a[7]^a[5], a[6:0]}: bits 8 and 7 are XORed with bits 4 and 5; all other bits pass through unchanged.
  - When xa_rd_s is low, xa_data_rd holds its last value.
  - Consecutive reads are fully pipelined at one result per cycle, each aligned one cycle after its address.
- Simultaneous xa_wr_s and xa_rd_s: both paths are independent; the write is forwarded and the read is served in the same cycle.
- Reset mid-operation
  - A read or write in flight when rst_n falls is discarded: no wa_wr_s pulse is issued and xa_data_rd=0.
  - After rst_n rises, the first edge with a strobe behaves normally.
- No internal storage beyond the output registers; no back-pressure or handshake beyond the strobes.

Decomposition:
- Shared package sif_pkg holds:
  - ADDR_W/DATA_W defaults.
  - Op encoding on {rst_n, wr_s, rd_s}: IDLE=3'b100, WRITE=3'b110, READ=3'b101, RESET=3'b0xx.
  - A pure function scramble_addr().
- One natural sub-module, sif_addr_scramble: combinational, ADDR_W in and ADDR_W out. The top instantiates it and registers its output.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with xa_addr=0x1234 and both strobes high -> all outputs 0 throughout; rst_n=1 -> outputs still 0 until a strobe is sampled.
- Single write: xa_addr=0x0040, xa_data_wr=0xBEEF, xa_wr_s=1 for one cycle -> next cycle wa_wr_s=1, wa_addr=0x0040, wa_data_wr=0xBEEF; the cycle after, wa_wr_s=0.
- Read scramble: back-to-back reads of 0x0110, 0x0020, 0x0180, 0xFFFF -> xa_data_rd=0x0010, 0x00A0, 0x0180, 0xFE7F on the four following cycles; the value then holds at 0xFE7F.
- Mixed traffic: write 0x0005/0x1111, then read 0x0020, then IDLE -> wa pulse carries 0x0005/0x1111; xa_data_rd=0x00A0 one cycle after the read; no extra wa pulse.
- Simultaneous strobes: xa_wr_s=xa_rd_s=1 with addr 0x0110, data 0xAAAA -> next cycle wa_wr_s=1, wa_addr=0x0110, wa_data_wr=0xAAAA, and xa_data_rd=0x0010.
- Reset mid-read: read 0x0020 issued, rst_n pulled low before the next edge -> xa_data_rd=0 (not 0x00A0), wa_wr_s=0; normal reads resume after release.
